// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------
// alu_pkg: opcodes and default width shared by the execute-stage ALU
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int WIDTH_DEF = 16;

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_ADC    = 3'd2;
  localparam logic [2:0] OP_SBC    = 3'd3;
  localparam logic [2:0] OP_AND    = 3'd4;
  localparam logic [2:0] OP_OR     = 3'd5;
  localparam logic [2:0] OP_XOR    = 3'd6;
  localparam logic [2:0] OP_PASS_B = 3'd7;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_addsub.sv
// ----------------------------------------------------------------
// alu_addsub: combinational add/subtract with carry/borrow and overflow
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none

module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] r,
  output logic             cout,
  output logic             v
);

  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic [WIDTH:0]   w_sum;

  // Subtraction as a + ~b + !borrow_in; the raw carry is inverted to report borrow.
  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = cin ^ sub;
  assign w_sum     = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin_eff};

  assign r    = w_sum[WIDTH-1:0];
  assign cout = w_sum[WIDTH] ^ sub;
  assign v    = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);

endmodule

`default_nettype wire

// File: rtl/ex_alu_stage.sv
// ----------------------------------------------------------------
// ex_alu_stage: registered ALU execute stage with valid/ready handshake
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none

module ex_alu_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_c,
  output logic             out_z,
  output logic             out_n,
  output logic             out_v
);

  logic             r_c;
  logic             w_accept;
  logic             w_arith;
  logic             w_cin;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_result;

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready && !flush;
  assign w_arith  = is_arith(in_op);
  assign w_cin    = ((in_op == OP_ADC) || (in_op == OP_SBC)) && r_c;
  assign w_sub    = (in_op == OP_SUB) || (in_op == OP_SBC);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (in_a),
    .b    (in_b),
    .cin  (w_cin),
    .sub  (w_sub),
    .r    (w_sum),
    .cout (w_cout),
    .v    (w_ovf)
  );

  always_comb begin
    w_result = w_sum;
    case (in_op)
      OP_AND:    w_result = in_a & in_b;
      OP_OR:     w_result = in_a | in_b;
      OP_XOR:    w_result = in_a ^ in_b;
      OP_PASS_B: w_result = in_b;
      default:   w_result = w_sum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_c      <= 1'b0;
      out_z      <= 1'b0;
      out_n      <= 1'b0;
      out_v      <= 1'b0;
      r_c        <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid  <= 1'b1;
      out_result <= w_result;
      out_c      <= w_arith & w_cout;
      out_v      <= w_arith & w_ovf;
      out_z      <= (w_result == '0);
      out_n      <= w_result[WIDTH-1];
      // Logic ops leave the carry flag alone so ADC/SBC chains survive them.
      if (w_arith) begin
        r_c <= w_cout;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_alu_stage.sv
// ----------------------------------------------------------------
// tb_ex_alu_stage: directed and randomized self-checking bench for ex_alu_stage
// Revision: 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_ex_alu_stage;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 4-bit instance for small boundary cases
  logic       a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
  logic [2:0] a_op;
  logic [3:0] a_a, a_b, a_res;
  logic       a_c, a_z, a_n, a_v;

  // 16-bit instance tracked by the reference model
  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
  logic [2:0]  b_op;
  logic [15:0] b_a, b_b, b_res;
  logic        b_c, b_z, b_n, b_v;

  ex_alu_stage #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op(a_op),
    .in_a(a_a), .in_b(a_b), .flush(a_flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_result(a_res), .out_c(a_c), .out_z(a_z), .out_n(a_n), .out_v(a_v)
  );

  ex_alu_stage #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_op),
    .in_a(b_a), .in_b(b_b), .flush(b_flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_result(b_res), .out_c(b_c), .out_z(b_z), .out_n(b_n), .out_v(b_v)
  );

  int checks   = 0;
  int failures = 0;

  // Reference state for the 16-bit instance
  localparam longint M = 65536;
  localparam longint H = 32768;
  bit     m_valid = 1'b0;
  bit     m_cf    = 1'b0;
  bit     m_c, m_z, m_n, m_v;
  longint m_res   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check in_ready mid-cycle, update model, cross the edge, check outputs.
  task automatic step(input string tag);
    bit     rdy, acc, arith;
    longint a, b, sa, sb, s, ideal, r;
    #1;
    rdy = !m_valid || b_out_ready;
    chk({tag, "/rdy16"}, 32'(b_in_ready), 32'(rdy));
    acc = b_in_valid && rdy && !b_flush;
    if (b_flush) begin
      m_valid = 1'b0;
    end else if (acc) begin
      a = longint'(b_a);
      b = longint'(b_b);
      sa = (a >= H) ? a - M : a;
      sb = (b >= H) ? b - M : b;
      arith = 1'b1;
      ideal = 0;
      case (b_op)
        3'd0: begin s = a + b;                     ideal = sa + sb; end
        3'd1: begin s = a - b;                     ideal = sa - sb; end
        3'd2: begin s = a + b + longint'(m_cf);    ideal = sa + sb + longint'(m_cf); end
        3'd3: begin s = a - b - longint'(m_cf);    ideal = sa - sb - longint'(m_cf); end
        3'd4: begin s = a & b; arith = 1'b0; end
        3'd5: begin s = a | b; arith = 1'b0; end
        3'd6: begin s = a ^ b; arith = 1'b0; end
        default: begin s = b; arith = 1'b0; end
      endcase
      if (arith) begin
        m_c  = (s < 0) || (s >= M);
        m_v  = (ideal >= H) || (ideal < -H);
        m_cf = m_c;
        r    = (s < 0) ? s + M : ((s >= M) ? s - M : s);
      end else begin
        m_c = 1'b0;
        m_v = 1'b0;
        r   = s;
      end
      m_res   = r;
      m_z     = (r == 0);
      m_n     = (r >= H);
      m_valid = 1'b1;
    end else if (b_out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, "/valid16"}, 32'(b_out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, "/res16"}, 32'(b_res), 32'(m_res));
      chk({tag, "/c16"}, 32'(b_c), 32'(m_c));
      chk({tag, "/z16"}, 32'(b_z), 32'(m_z));
      chk({tag, "/n16"}, 32'(b_n), 32'(m_n));
      chk({tag, "/v16"}, 32'(b_v), 32'(m_v));
    end
  endtask

  task automatic op4(input string tag, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] er, input logic ec, input logic ez, input logic en, input logic ev);
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    a_flush     = 1'b0;
    a_op = op; a_a = a; a_b = b;
    step(tag);
    chk({tag, "/valid"}, 32'(a_out_valid), 32'd1);
    chk({tag, "/res"}, 32'(a_res), 32'(er));
    chk({tag, "/c"}, 32'(a_c), 32'(ec));
    chk({tag, "/z"}, 32'(a_z), 32'(ez));
    chk({tag, "/n"}, 32'(a_n), 32'(en));
    chk({tag, "/v"}, 32'(a_v), 32'(ev));
  endtask

  function automatic logic [15:0] pick16();
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_flush = 1'b0; a_op = '0; a_a = '0; a_b = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_flush = 1'b0; b_op = '0; b_a = '0; b_b = '0;

    // Asynchronous reset, observed before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst/valid4", 32'(a_out_valid), 32'd0);
    chk("rst/res4", 32'(a_res), 32'd0);
    chk("rst/flags4", 32'({a_c, a_z, a_n, a_v}), 32'd0);
    chk("rst/valid16", 32'(b_out_valid), 32'd0);
    chk("rst/res16", 32'(b_res), 32'd0);
    chk("rst/flags16", 32'({b_c, b_z, b_n, b_v}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Small-width arithmetic boundaries
    op4("add10_7", 3'd0, 4'd10, 4'd7, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    op4("sub1_4", 3'd1, 4'd1, 4'd4, 4'd13, 1'b1, 1'b0, 1'b1, 1'b0);
    op4("add7_1", 3'd0, 4'd7, 4'd1, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1);
    op4("adc15_0", 3'd2, 4'd15, 4'd0, 4'd15, 1'b0, 1'b0, 1'b1, 1'b0);

    // Flush with a simultaneous accept: no output, carry flag untouched
    a_op = 3'd0; a_a = 4'd15; a_b = 4'd1; a_flush = 1'b1; a_in_valid = 1'b1;
    step("flush");
    chk("flush/valid4", 32'(a_out_valid), 32'd0);
    op4("adc0_0", 3'd2, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Output hold under back-pressure
    op4("add3_4", 3'd0, 4'd3, 4'd4, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    a_op = 3'd6; a_a = 4'd5; a_b = 4'd3; a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("hold");
      chk("hold/rdy4", 32'(a_in_ready), 32'd0);
      chk("hold/valid4", 32'(a_out_valid), 32'd1);
      chk("hold/res4", 32'(a_res), 32'd7);
    end
    a_out_ready = 1'b1;
    #1;
    chk("release/rdy4", 32'(a_in_ready), 32'd1);
    step("release");
    chk("release/valid4", 32'(a_out_valid), 32'd1);
    chk("release/res4", 32'(a_res), 32'd6);
    a_in_valid = 1'b0;
    step("drain");
    chk("drain/valid4", 32'(a_out_valid), 32'd0);

    // Back-to-back carry chain at 16 bits
    b_in_valid = 1'b1; b_out_ready = 1'b1;
    b_op = 3'd0; b_a = 16'hFFFF; b_b = 16'h0001;
    step("chain1");
    chk("chain1/res", 32'(b_res), 32'd0);
    chk("chain1/zc", 32'({b_z, b_c}), 32'b11);
    b_op = 3'd2; b_a = 16'h0000; b_b = 16'h0000;
    step("chain2");
    chk("chain2/res", 32'(b_res), 32'd1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_flush     = ($urandom_range(0, 15) == 0);
      b_op = 3'($urandom);
      b_a  = pick16();
      b_b  = pick16();
      step("rand");
    end

    // Reset mid-operation after setting the carry flag
    b_flush = 1'b0; b_in_valid = 1'b1; b_out_ready = 1'b1;
    b_op = 3'd0; b_a = 16'hFFFF; b_b = 16'h0002;
    step("prerst");
    b_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst/valid16", 32'(b_out_valid), 32'd0);
    chk("midrst/res16", 32'(b_res), 32'd0);
    chk("midrst/flags16", 32'({b_c, b_z, b_n, b_v}), 32'd0);
    m_valid = 1'b0;
    m_cf    = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    b_in_valid = 1'b1; b_op = 3'd2; b_a = 16'd5; b_b = 16'd0;
    step("postrst");
    chk("postrst/res16", 32'(b_res), 32'd5);
    b_in_valid = 1'b0;
    step("idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_alu_stage.md
EX_ALU_STAGE -- requirements
Module: ex_alu_stage

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits (legal range 4..32).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream (decode) presents an operation.
REQ-005 in_ready  output  1  stage can accept an operation this cycle.
REQ-006 in_op  input  3  opcode: ADD=0, SUB=1, ADC=2, SBC=3, AND=4, OR=5, XOR=6, PASS_B=7.
REQ-007 in_a  input  WIDTH  operand A.
REQ-008 in_b  input  WIDTH  operand B.
REQ-009 flush  input  1  discard the held result and the incoming operation (branch mispredict).
REQ-010 out_valid  output  1  registered result is present for the memory stage.
REQ-011 out_ready  input  1  downstream accepts the result this cycle.
REQ-012 out_result  output  WIDTH  registered result.
REQ-013 out_c  output  1  carry flag: carry-out for ADD/ADC, borrow for SUB/SBC.
REQ-014 out_z, out_n, out_v  output  1 each  zero, negative (result MSB), signed overflow.

Function
REQ-015 Handshake: in_ready = !out_valid || out_ready (combinational); an op is accepted when in_valid && in_ready && !flush.
REQ-016 Latency: an accepted op appears on out_* on the next rising edge, with out_valid=1.
REQ-017 Output hold: while out_valid && !out_ready, all out_* stay stable and no op is accepted.
REQ-018 Drain: if out_valid && out_ready and no op is accepted, out_valid clears next edge.
REQ-019 ADD: {c,r} = a + b, WIDTH+1-bit sum; c = bit WIDTH.
REQ-020 SUB: {c,r} = a - b, WIDTH+1-bit difference; c = 1 when a < b unsigned (borrow).
REQ-021 ADC: {c,r} = a + b + C; SBC: {c,r} = a - b - C; C is the internal carry-flag register.
REQ-022 V: ADD/ADC set when a and b share a sign and r differs from it; SUB/SBC set when a and b differ in sign and r differs from a.
REQ-023 Logic ops and PASS_B: r per opcode, out_c and out_v = 0, and the carry-flag register is unchanged.
REQ-024 out_z = (r == 0); out_n = r[WIDTH-1]; both apply to every opcode.
REQ-025 Carry-flag register C updates only on an accepted arithmetic op (opcodes 0-3). C is forwarded combinationally from the accepted op's result, so back-to-back ADC/SBC chains work at full rate.
REQ-026 Flush: on the next edge out_valid=0, the incoming op is dropped, and C is not updated. Flush overrides a simultaneous accept and a stalled output.
REQ-027 Wrap-around: results are modulo 2^WIDTH. Carry and borrow are reported only through out_c.

Reset
REQ-028 When rst is asserted, asynchronously: out_valid=0, out_result=0, out_c=0, out_z=0, out_n=0, out_v=0, C=0.
REQ-029 Reset mid-operation discards the held result; the first accept after deassertion behaves as after power-up.

Structure
REQ-030 Opcode localparams and the WIDTH default reside in the shared package alu_pkg.
REQ-031 The combinational arithmetic lives in sub-module alu_addsub (a, b, cin, sub → r, cout, v); ex_alu_stage contains the handshake and registers only.

Verification
REQ-032 WIDTH=4, ADD a=10 b=7 → out_result=1, out_c=1, out_v=0, out_z=0.
REQ-033 WIDTH=4, SUB a=1 b=4 → out_result=13, out_c=1 (borrow), out_n=1, out_v=0.
REQ-034 WIDTH=4, ADD 7+1 → out_result=8, out_v=1, out_n=1; then ADC 15+0 with C=0 → out_result=15, out_c=0.
REQ-035 WIDTH=16, ADD 0xFFFF+1 then ADC 0+0 back-to-back → first: result 0, out_z=1, out_c=1; second: result 1.
REQ-036 Hold out_ready=0 for 3 cycles with in_valid=1 → out_* stable and in_ready=0; release → queued op appears next edge.
REQ-037 Assert flush together with an accept of ADD 15+1 (WIDTH=4) → out_valid=0 next edge and C unchanged; a following ADC 0+0 yields 0.
